mem_arbiter_ctrl: RTL and testbench

Memory-side responder for the caches_if protocol. Serves word requests from the icache (read-only) and the dcache (read/write) to a single-ported RAM. Arbitrates between the two with dcache priority plus an anti-starvation limit, and drives the wait/load handshake back to each cache. Sits between the cache pair and the RAM model, taking the role the caches address as "memory".

---
 rtl/mem_arbiter_ctrl_pkg.sv | 22 ++
 rtl/mem_arbiter_ctrl_if.sv | 36 +++
 rtl/mem_arbiter_ctrl_streak.sv | 44 ++++
 rtl/mem_arbiter_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types for the memory arbiter: RAM status encoding and arbiter states.
package mem_arbiter_ctrl_pkg;

    // Status reported by the RAM model each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter states: idle/arbitrating, serving a cache, or stuck in error.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D_ACC = 2'd1,
        I_ACC = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    localparam int WORD_W = 32;

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Cache-pair and RAM-side signals seen by the memory arbiter.
interface mem_arbiter_ctrl_if;
    import mem_arbiter_ctrl_pkg::*;

    logic                iREN;
    logic [WORD_W-1:0]   iaddr;
    logic                iwait;
    logic [WORD_W-1:0]   iload;

    logic                dREN;
    logic                dWEN;
    logic [WORD_W-1:0]   daddr;
    logic [WORD_W-1:0]   dstore;
    logic                dwait;
    logic [WORD_W-1:0]   dload;

    logic                ramREN;
    logic                ramWEN;
    logic [WORD_W-1:0]   ramaddr;
    logic [WORD_W-1:0]   ramstore;
    logic [WORD_W-1:0]   ramload;
    ramstate_t           ramstate;

    // The arbiter's view: requests and RAM status come in, handshakes and RAM controls go out.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // The environment's view: caches plus RAM model.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_ctrl_streak.sv
// Counts consecutive dcache completions while the icache is waiting and
// forces an icache grant once the limit is reached.
module mem_arb_streak #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic d_done_i,
    input  logic i_done_i,
    input  logic iren_i,
    output logic force_i_o
);

    localparam logic [3:0] MAX_L = 4'(MAX_D_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;

    // Next streak: icache service clears it, dcache service bumps it only while icache waits.
    always_comb begin
        streak_d = streak_q;
        if (i_done_i) begin
            streak_d = 4'd0;
        end else if (d_done_i) begin
            if (iren_i) begin
                streak_d = (streak_q == MAX_L) ? streak_q : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end
    end

    // Streak register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_i_o = iren_i && (streak_q == MAX_L);

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Memory-side responder for the icache/dcache pair: dcache-priority arbiter
// with an anti-starvation limit, per-access timeout and transfer counters.
module mem_arbiter_ctrl
    import mem_arbiter_ctrl_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                CLK,
    input  logic                nRST,
    mem_arbiter_ctrl_if.slave   bus,
    output logic                err_o,
    output logic [WORD_W-1:0]   d_xfers_o,
    output logic [WORD_W-1:0]   i_xfers_o
);

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [7:0]          timer_q, timer_d;
    logic [WORD_W-1:0]   d_xfers_q, d_xfers_d;
    logic [WORD_W-1:0]   i_xfers_q, i_xfers_d;
    logic                d_done;
    logic                i_done;
    logic                force_i;
    logic                dreq;

    assign dreq = bus.dREN | bus.dWEN;

    mem_arb_streak #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .CLK       (CLK),
        .nRST      (nRST),
        .d_done_i  (d_done),
        .i_done_i  (i_done),
        .iren_i    (bus.iREN),
        .force_i_o (force_i)
    );

    // Next state, timer and all handshake/RAM outputs; outputs are quiet unless a grant is active.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        d_done       = 1'b0;
        i_done       = 1'b0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        err_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq && !force_i) begin
                    state_d = D_ACC;
                    timer_d = 8'd0;
                end else if (bus.iREN) begin
                    state_d = I_ACC;
                    timer_d = 8'd0;
                end
            end

            D_ACC: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (bus.ramstate == ERROR) begin
                    state_d = ERR;
                end else if (!dreq) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.dWEN ? '0 : bus.ramload;
                    d_done    = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TIMEOUT_L - 8'd1) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            I_ACC: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (bus.ramstate == ERROR) begin
                    state_d = ERR;
                end else if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    i_done    = 1'b1;
                    state_d   = IDLE;
                end else if (timer_q == TIMEOUT_L - 8'd1) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            ERR: begin
                err_o = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completed-transfer counters, wrapping naturally at 32 bits.
    always_comb begin
        d_xfers_d = d_done ? d_xfers_q + 32'd1 : d_xfers_q;
        i_xfers_d = i_done ? i_xfers_q + 32'd1 : i_xfers_q;
    end

    // State, timer and counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            timer_q   <= 8'd0;
            d_xfers_q <= '0;
            i_xfers_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            d_xfers_q <= d_xfers_d;
            i_xfers_q <= i_xfers_d;
        end
    end

    assign d_xfers_o = d_xfers_q;
    assign i_xfers_o = i_xfers_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Testbench for mem_arbiter_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter_ctrl;
    import mem_arbiter_ctrl_pkg::*;

    localparam int MAXS = 4;
    localparam int TMO  = 64;

    localparam int OWN_NONE = 0;
    localparam int OWN_D    = 1;
    localparam int OWN_I    = 2;
    localparam int OWN_ERR  = 3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        err;
    logic [31:0] dx;
    logic [31:0] ix;

    int errors = 0;
    int checks = 0;

    mem_arbiter_ctrl_if bus ();

    mem_arbiter_ctrl #(
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TMO)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.slave),
        .err_o     (err),
        .d_xfers_o (dx),
        .i_xfers_o (ix)
    );

    always #5 CLK = ~CLK;

    // Reference model: who currently owns the RAM, how long it has waited,
    // how many dcache grants in a row the icache has watched, and totals.
    int          mOwner  = OWN_NONE;
    int          mAge    = 0;
    int          mStreak = 0;
    logic [31:0] mD      = '0;
    logic [31:0] mI      = '0;
    logic        mDreq;

    assign mDreq = bus.dREN | bus.dWEN;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            mOwner  <= OWN_NONE;
            mAge    <= 0;
            mStreak <= 0;
            mD      <= '0;
            mI      <= '0;
        end else begin
            if (mOwner == OWN_NONE) begin
                if (mDreq && !(bus.iREN && mStreak == MAXS)) begin
                    mOwner <= OWN_D;
                    mAge   <= 0;
                end else if (bus.iREN) begin
                    mOwner <= OWN_I;
                    mAge   <= 0;
                end
            end else if (mOwner == OWN_D || mOwner == OWN_I) begin
                if (bus.ramstate == ERROR) begin
                    mOwner <= OWN_ERR;
                end else if ((mOwner == OWN_D) ? !mDreq : !bus.iREN) begin
                    mOwner <= OWN_NONE;
                end else if (bus.ramstate == ACCESS) begin
                    mOwner <= OWN_NONE;
                    if (mOwner == OWN_D) begin
                        mD      <= mD + 1;
                        mStreak <= bus.iREN ? ((mStreak < MAXS) ? mStreak + 1 : MAXS) : 0;
                    end else begin
                        mI      <= mI + 1;
                        mStreak <= 0;
                    end
                end else if (mAge + 1 >= TMO) begin
                    mOwner <= OWN_ERR;
                end else begin
                    mAge <= mAge + 1;
                end
            end
        end
    end

    logic        expIwait, expDwait, expRen, expWen, expErr;
    logic [31:0] expIload, expDload, expAddr, expStore;

    always_comb begin
        expIwait = 1'b1;
        expDwait = 1'b1;
        expIload = '0;
        expDload = '0;
        expRen   = 1'b0;
        expWen   = 1'b0;
        expAddr  = '0;
        expStore = '0;
        expErr   = (mOwner == OWN_ERR);
        if (mOwner == OWN_D) begin
            expAddr  = bus.daddr;
            expStore = bus.dstore;
            expWen   = bus.dWEN;
            expRen   = bus.dREN && !bus.dWEN;
            if (bus.ramstate == ACCESS && mDreq) begin
                expDwait = 1'b0;
                expDload = bus.dWEN ? 32'd0 : bus.ramload;
            end
        end else if (mOwner == OWN_I) begin
            expAddr = bus.iaddr;
            expRen  = 1'b1;
            if (bus.ramstate == ACCESS && bus.iREN) begin
                expIwait = 1'b0;
                expIload = bus.ramload;
            end
        end
    end

    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [31:0] da, input logic [31:0] ds,
                                 input logic [31:0] rl, input ramstate_t rs);
        bus.iREN     = ir;
        bus.iaddr    = ia;
        bus.dREN     = dr;
        bus.dWEN     = dw;
        bus.daddr    = da;
        bus.dstore   = ds;
        bus.ramload  = rl;
        bus.ramstate = rs;
    endtask

    task automatic applyReset();
        @(negedge CLK);
        nRST = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, FREE);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 32'h44, 1'b1, 1'b1, 32'h88, 32'h99, 32'h1234, ACCESS);
        #2 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if ({bus.iwait, bus.dwait} !== 2'b11) begin
            errors++; $display("[TB] FAIL reset_waits: got=%b expected=11", {bus.iwait, bus.dwait});
        end
        checks++;
        if ({bus.iload, bus.dload} !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_loads: got=%h/%h expected=0/0", bus.iload, bus.dload);
        end
        checks++;
        if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_ram_en: got=%b expected=00", {bus.ramREN, bus.ramWEN});
        end
        checks++;
        if ({bus.ramaddr, bus.ramstore} !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_ram_bus: got=%h/%h expected=0/0", bus.ramaddr, bus.ramstore);
        end
        checks++;
        if ({err, dx, ix} !== 65'd0) begin
            errors++; $display("[TB] FAIL reset_status: got err=%b d=%0d i=%0d expected 0/0/0", err, dx, ix);
        end
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, FREE);
        nRST = 1'b1;
    endtask

    task automatic test_single_read();
        ramstate_t rs;
        applyReset();
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            rs = (c == 0) ? FREE : (c == 3) ? ACCESS : BUSY;
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, 32'h5, 32'hDEADBEEF, rs);
            #1;
            checks++;
            if (bus.ramREN !== (c >= 1) || (c >= 1 && bus.ramaddr !== 32'h100)) begin
                errors++; $display("[TB] FAIL read_ram c=%0d: got ren=%b addr=%h", c, bus.ramREN, bus.ramaddr);
            end
            checks++;
            if (bus.dwait !== (c != 3) || bus.dload !== ((c == 3) ? 32'hDEADBEEF : 32'd0)) begin
                errors++; $display("[TB] FAIL read_done c=%0d: got dwait=%b dload=%h", c, bus.dwait, bus.dload);
            end
        end
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, FREE);
        #1;
        checks++;
        if (dx !== 32'd1) begin
            errors++; $display("[TB] FAIL read_count: got=%0d expected=1", dx);
        end
    endtask

    task automatic test_priority();
        logic dPend = 1'b1;
        logic iPend = 1'b1;
        int   dAt = -1;
        int   iAt = -1;
        int   both = 0;
        applyReset();
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            applyStimulus(iPend, 32'h200, dPend, 1'b0, 32'h300, '0, 32'hC0DE0000 + c, ACCESS);
            #1;
            if (!bus.iwait && !bus.dwait) both++;
            if (!bus.dwait && dAt < 0) begin dAt = c; dPend = 1'b0; end
            if (!bus.iwait && iAt < 0) begin iAt = c; iPend = 1'b0; end
        end
        checks++;
        if (dAt != 1 || iAt != 3) begin
            errors++; $display("[TB] FAIL priority_order: got d@%0d i@%0d expected d@1 i@3", dAt, iAt);
        end
        checks++;
        if (both != 0) begin
            errors++; $display("[TB] FAIL priority_overlap: got=%0d expected=0", both);
        end
    endtask

    task automatic test_streak();
        string seq = "";
        applyReset();
        for (int c = 0; c < 14; c++) begin
            @(negedge CLK);
            applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 32'h30 + c, 32'h77, ACCESS);
            #1;
            if (!bus.dwait) seq = {seq, "D"};
            if (!bus.iwait) seq = {seq, "I"};
            checks++;
            if (bus.iwait !== expIwait || bus.dwait !== expDwait) begin
                errors++; $display("[TB] FAIL streak_waits c=%0d: got=%b%b expected=%b%b", c, bus.iwait, bus.dwait, expIwait, expDwait);
            end
        end
        checks++;
        if (seq != "DDDDIDD") begin
            errors++; $display("[TB] FAIL streak_order: got=%s expected=DDDDIDD", seq);
        end
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, FREE);
        #1;
        checks++;
        if (ix !== 32'd1 || dx !== 32'd6) begin
            errors++; $display("[TB] FAIL streak_counts: got i=%0d d=%0d expected i=1 d=6", ix, dx);
        end
    endtask

    task automatic test_write();
        applyReset();
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'hAAAA5555, FREE);
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'hAAAA5555, BUSY);
        #1;
        checks++;
        if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramstore !== 32'h12345678 || bus.ramaddr !== 32'h40) begin
            errors++; $display("[TB] FAIL write_bus: got wen=%b ren=%b store=%h addr=%h", bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
        end
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'hAAAA5555, ACCESS);
        #1;
        checks++;
        if (bus.dwait !== 1'b0 || bus.dload !== 32'd0) begin
            errors++; $display("[TB] FAIL write_done: got dwait=%b dload=%h expected 0/0", bus.dwait, bus.dload);
        end
    endtask

    task automatic test_timeout();
        int firstErr = -1;
        applyReset();
        for (int c = 0; c < 100 && firstErr < 0; c++) begin
            @(negedge CLK);
            applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 32'h1, BUSY);
            #1;
            if (err) firstErr = c;
        end
        checks++;
        if (firstErr != 65) begin
            errors++; $display("[TB] FAIL timeout_cycle: got=%0d expected=65", firstErr);
        end
        repeat (3) @(negedge CLK);
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, '0, '0, 32'h1, ACCESS);
        #1;
        checks++;
        if (err !== 1'b1 || bus.iwait !== 1'b1 || bus.ramREN !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_hold: got err=%b iwait=%b ren=%b expected 1/1/0", err, bus.iwait, bus.ramREN);
        end
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0 || ix !== 32'd0 || bus.ramREN !== 1'b0 || bus.iwait !== 1'b1) begin
            errors++; $display("[TB] FAIL timeout_clear: got err=%b i=%0d ren=%b iwait=%b", err, ix, bus.ramREN, bus.iwait);
        end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset_mid();
        applyReset();
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h60, 32'hABCD, '0, BUSY);
        @(negedge CLK);
        #1;
        checks++;
        if (bus.ramWEN !== 1'b1) begin
            errors++; $display("[TB] FAIL midreset_pre: got wen=%b expected=1", bus.ramWEN);
        end
        @(negedge CLK);
        nRST = 1'b0;
        bus.ramstate = ACCESS;
        #1;
        checks++;
        if (bus.dwait !== 1'b1 || bus.ramWEN !== 1'b0 || dx !== 32'd0) begin
            errors++; $display("[TB] FAIL midreset_abort: got dwait=%b wen=%b d=%0d expected 1/0/0", bus.dwait, bus.ramWEN, dx);
        end
        @(negedge CLK);
        nRST = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h64, '0, 32'h600D, ACCESS);
        @(negedge CLK);
        #1;
        checks++;
        if (bus.dwait !== 1'b0 || bus.dload !== 32'h600D) begin
            errors++; $display("[TB] FAIL midreset_next: got dwait=%b dload=%h expected 0/600d", bus.dwait, bus.dload);
        end
        @(negedge CLK);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, FREE);
        #1;
        checks++;
        if (dx !== 32'd1) begin
            errors++; $display("[TB] FAIL midreset_count: got=%0d expected=1", dx);
        end
    endtask

    task automatic test_random();
        int unsigned r;
        int unsigned k;
        ramstate_t   rs;
        logic        dr, dw;
        int          errHold = 0;
        applyReset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (!nRST) begin
                nRST = 1'b1;
            end else if (mOwner == OWN_ERR) begin
                errHold++;
                if (errHold > 3) begin
                    nRST = 1'b0;
                    errHold = 0;
                end
            end
            r  = $urandom_range(0, 99);
            rs = (r < 40) ? BUSY : (r < 50) ? FREE : (r < 99) ? ACCESS : ERROR;
            k  = $urandom_range(0, 7);
            dr = (k >= 2 && k <= 4) || k == 7;
            dw = (k >= 5);
            applyStimulus($urandom_range(0, 3) != 0, $urandom, dr, dw, $urandom, $urandom, $urandom, rs);
            #1;
            checks++;
            if (bus.iwait !== expIwait || bus.dwait !== expDwait) begin
                errors++; $display("[TB] FAIL rnd_waits c=%0d: got=%b%b expected=%b%b", c, bus.iwait, bus.dwait, expIwait, expDwait);
            end
            checks++;
            if (bus.iload !== expIload || bus.dload !== expDload) begin
                errors++; $display("[TB] FAIL rnd_loads c=%0d: got=%h/%h expected=%h/%h", c, bus.iload, bus.dload, expIload, expDload);
            end
            checks++;
            if (bus.ramREN !== expRen || bus.ramWEN !== expWen) begin
                errors++; $display("[TB] FAIL rnd_ram_en c=%0d: got=%b%b expected=%b%b", c, bus.ramREN, bus.ramWEN, expRen, expWen);
            end
            checks++;
            if (bus.ramaddr !== expAddr || bus.ramstore !== expStore) begin
                errors++; $display("[TB] FAIL rnd_ram_bus c=%0d: got=%h/%h expected=%h/%h", c, bus.ramaddr, bus.ramstore, expAddr, expStore);
            end
            checks++;
            if (err !== expErr || dx !== mD || ix !== mI) begin
                errors++; $display("[TB] FAIL rnd_status c=%0d: got err=%b d=%0d i=%0d expected err=%b d=%0d i=%0d", c, err, dx, ix, expErr, mD, mI);
            end
        end
    endtask

    initial begin
        $display("[TB] starting mem_arbiter_ctrl bench");
        test_reset();
        test_single_read();
        test_priority();
        test_streak();
        test_write();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
